muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit holding architectural HI/LO for the MIPS datapath.
//  - Replaces the combinational multiply path and the mfhi/mflo path of the single-cycle ALU.
//  - Computes one bit per cycle; the control unit stalls the datapath while busy=1.
//  - Supports signed/unsigned multiply and divide, plus direct HI/LO writes (mthi/mtlo).
// PARAMETERS
//  WIDTH      32  operand width; HI and LO are each WIDTH bits
//  CNT_W      6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk     in   1      clock, all state on rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      op request; honoured only when busy=0
//  op      in   3      muldiv_pkg::md_op_t, sampled with start
//  a       in   WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
//  b       in   WIDTH  rt operand (divisor / multiplier)
//  flush   in   1      cancel op in flight (exception/branch squash)
//  hi      out  WIDTH  architectural HI register
//  lo      out  WIDTH  architectural LO register
//  busy    out  1      op in progress; HI/LO not yet updated
//  done    out  1      one-cycle pulse: HI/LO just updated by MULT/DIV
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset mid-op aborts with no done pulse.
//  Ops: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6-7 are ignored (no state change).
//  FSM IDLE -> CALC -> FIX -> IDLE.
//   IDLE:
//    - start with MULT/DIV/MULTU/DIVU: latch |a|,|b| (signed ops) or a,b; latch result signs;
//      count=WIDTH; go to CALC.
//    - start with MTHI/MTLO: hi<=a or lo<=a at that edge; stay IDLE; no busy, no done.
//   CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle;
//    count decrements; go to FIX after the step taken with count==1.
//   FIX: apply sign correction; write hi/lo at the FIX edge; done=1 for the next cycle; go to IDLE.
//  Latency: start sampled at end of cycle N.
//   - busy=1 in cycles N+1 .. N+WIDTH+1.
//   - hi/lo new and done=1 in cycle N+WIDTH+2 (34 cycles for WIDTH=32).
//  start while busy=1 is ignored; there is no queueing.
//  A new start may be issued in the same cycle done=1.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product; signed result is the two's complement of the
//   magnitude product when the operand signs differ.
//  DIV/DIVU: lo=quotient, hi=remainder.
//   - Signed quotient truncates toward zero; remainder takes the sign of a.
//   - b==0: lo = all ones, hi = a (signed and unsigned). No trap.
//   - Signed MIN / -1: lo=MIN, hi=0.
//  flush in any cycle: next state IDLE, busy=0, hi/lo keep their old values, no done.
//   - flush has priority over start in the same cycle.
//   - flush in the FIX cycle suppresses the write.
//  hi/lo are driven directly from registers: stable, holding old values while busy.
// STRUCTURE
//  muldiv_pkg:
//   - md_op_t enum (codes above); MD_IDLE/MD_CALC/MD_FIX state encodings.
//   - function div_by_zero_result(a) returning the {hi,lo} pair.
//  Sub-module md_abs_neg (WIDTH param): conditional two's-complement negate.
//   Instanced for operand magnitudes and FIX-stage result correction.
//  Single shared 2*WIDTH accumulator/shift register used for both mul and div.
// TESTING (WIDTH=32)
//  1. MULT a=FFFFFFFF b=00000002 -> hi=FFFFFFFF lo=FFFFFFFE; done exactly 34 cycles after start.
//  2. MULTU a=FFFFFFFF b=00000002 -> hi=00000001 lo=FFFFFFFE; busy high 33 cycles.
//  3. DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU a=100 b=7 -> lo=14 hi=2.
//  4. DIVU a=00000064 b=0 -> lo=FFFFFFFF hi=00000064; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  5. MTHI a=12345678 then MTLO a=9ABCDEF0 on consecutive cycles -> hi/lo updated next edge, busy never set;
//     start MULT while busy -> ignored, result of first op only.
//  6. MULT started, flush at cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done;
//     reset at cycle 20 of a DIV -> hi=lo=0, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operand width the package helpers are written for.
  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Divide by zero does not trap: quotient saturates to all ones, remainder is the dividend.
  function automatic logic [2*MD_WIDTH-1:0] div_by_zero_result(input logic [MD_WIDTH-1:0] a);
    return {a, {MD_WIDTH{1'b1}}};
  endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module md_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit holding the architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  md_state_t          state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // shared product / remainder:quotient shift register
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // product / quotient negative
  logic               rem_neg_q, rem_neg_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  md_op_t             op_e;
  logic               signed_op;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] mul_acc, div_acc;

  assign op_e      = md_op_t'(op);
  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign sa        = signed_op & a[WIDTH-1];
  assign sb        = signed_op & b[WIDTH-1];

  md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.val_i(a), .neg_i(sa), .val_o(a_mag));
  md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.val_i(b), .neg_i(sb), .val_o(b_mag));

  md_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_q), .val_o(prod_fix));
  md_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i(acc_q[WIDTH-1:0]),
    .neg_i(neg_q),
    .val_o(quo_fix)
  );
  md_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]),
    .neg_i(rem_neg_q),
    .val_o(rem_fix)
  );

  // One shift-add multiply step: add multiplicand into the upper half on LSB, shift right.
  always_comb begin
    logic [WIDTH:0] sum;
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    if (acc_q[0]) begin
      mul_acc = {sum, acc_q[WIDTH-1:1]};
    end else begin
      mul_acc = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // One restoring divide step: shift left, subtract divisor if it fits, shift in quotient bit.
  always_comb begin
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    // Difference is below the divisor whenever it is used, so the low WIDTH bits suffice.
    rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
    if (rem_sh >= {1'b0, opnd_q}) begin
      div_acc = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic: operand capture, iteration, result write-back, flush cancel.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (op_e)
            MD_MULT, MD_MULTU: begin
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opnd_d   = a_mag;
              neg_d    = sa ^ sb;
              is_div_d = 1'b0;
              count_d  = CNT_W'(WIDTH);
              state_d  = MD_CALC;
            end
            MD_DIV, MD_DIVU: begin
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opnd_d    = b_mag;
              neg_d     = sa ^ sb;
              rem_neg_d = sa;
              bzero_d   = (b == '0);
              is_div_d  = 1'b1;
              count_d   = CNT_W'(WIDTH);
              state_d   = MD_CALC;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MD_CALC: begin
        acc_d   = is_div_q ? div_acc : mul_acc;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (bzero_q) begin
          // Remainder magnitude equals |a| here, so the sign-corrected remainder is a itself.
          {hi_d, lo_d} = div_by_zero_result(rem_fix);
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    // Squash wins over everything, including a same-cycle start or the FIX write.
    if (flush) begin
      state_d = MD_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != MD_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives start for one cycle, then waits for done (bounded).
  // lat = cycle index of done relative to the start cycle, busy_n = busy cycles seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int busy_n);
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Count cycles with done or busy asserted over n cycles.
  task automatic watch(input int n, output int act);
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || busy) act++;
    end
  endtask

  int lat, bn, act;

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    // MULT -1 * 2
    run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, lat, bn);
    check("mult_lat", 64'(lat), 64'd34);
    check("mult_busy", 64'(bn), 64'd33);
    check("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

    // MULTU issued in the same cycle done=1
    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, lat, bn);
    check("multu_lat", 64'(lat), 64'd34);
    check("multu_busy", 64'(bn), 64'd33);
    check("multu_res", {hi, lo}, 64'h00000001_FFFFFFFE);
    @(negedge clk);
    check("done_pulse_1cyc", 64'(done), 64'h0);

    // DIV -7 / 2 and DIVU 100 / 7
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, lat, bn);
    check("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd3, 32'd100, 32'd7, lat, bn);
    check("divu_lat", 64'(lat), 64'd34);
    check("divu_res", {hi, lo}, {32'd2, 32'd14});

    // Divide-by-zero and overflow corners
    run_op(3'd3, 32'h00000064, 32'h0, lat, bn);
    check("divu_by0", {hi, lo}, 64'h00000064_FFFFFFFF);
    run_op(3'd2, 32'hFFFFFF9C, 32'h0, lat, bn);
    check("div_neg_by0", {hi, lo}, 64'hFFFFFF9C_FFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bn);
    check("div_min_m1", {hi, lo}, 64'h00000000_80000000);
    run_op(3'd0, 32'h80000000, 32'h80000000, lat, bn);
    check("mult_min_min", {hi, lo}, 64'h40000000_00000000);
    run_op(3'd0, 32'hFFFFFFFD, 32'h00000007, lat, bn);
    check("mult_neg3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'h0);
    op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo_hi_kept", 64'(hi), 64'h12345678);
    check("mtlo_busy", 64'(busy), 64'h0);
    check("mt_no_done", 64'(done), 64'h0);

    // Reserved op code: no state change
    start = 1'b1; op = 3'd6; a = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rsvd_op", {hi, lo}, 64'h12345678_9ABCDEF0);
    check("rsvd_busy", 64'(busy), 64'h0);

    // MULT 3*5 with ignored starts while busy; HI/LO hold old values meanwhile
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    op = 3'd1; a = 32'd1000; b = 32'd1000;
    repeat (5) @(negedge clk);
    start = 1'b0;
    check("busy_hold_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    lat = 6;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("ignored_start_lat", 64'(lat), 64'd34);
    check("ignored_start_res", {hi, lo}, 64'h00000000_0000000F);
    watch(40, act);
    check("no_queued_op", 64'(act), 64'd0);

    // flush beats a same-cycle start
    start = 1'b1; op = 3'd5; a = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_vs_mtlo", 64'(lo), 64'h0000000F);

    // flush a MULT at cycle 10
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'h0);
    watch(40, act);
    check("flush_no_done", 64'(act), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h00000000_0000000F);

    // flush exactly in the FIX cycle suppresses the write
    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix_done", 64'(done), 64'h0);
    check("flush_fix_hilo", {hi, lo}, 64'h00000000_0000000F);

    // reset at cycle 20 of a DIV
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_hilo", {hi, lo}, 64'h0);
    check("reset_mid_busy", 64'(busy), 64'h0);
    watch(40, act);
    check("reset_mid_no_done", 64'(act), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
